// File: rtl/conv_frame_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : conv_frame_streamer
// Description : Captures ROWS x COLS binary frames row by row, then streams
//               every KxK sliding window in raster order over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_frame_streamer #(
    parameter int COLS = 6,
    parameter int ROWS = 6,
    parameter int K    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COLS-1:0]           row_data,
    input  logic                      row_strobe,
    input  logic                      load_go,
    input  logic                      win_ready,
    output logic                      win_valid,
    output logic [K*K-1:0]            win_data,
    output logic [$clog2(ROWS)-1:0]   win_row,
    output logic [$clog2(COLS)-1:0]   win_col,
    output logic                      frame_full,
    output logic                      done,
    output logic                      ovf_err
);

    localparam int c_RW = $clog2(ROWS);
    localparam int c_CW = $clog2(COLS);
    localparam int c_WW = $clog2(ROWS + 1);

    localparam logic [c_RW-1:0] c_LAST_ROW = c_RW'(ROWS - K);
    localparam logic [c_CW-1:0] c_LAST_COL = c_CW'(COLS - K);
    localparam logic [c_WW-1:0] c_LAST_WR  = c_WW'(ROWS - 1);

    localparam logic [1:0] c_ST_FILL   = 2'd0;
    localparam logic [1:0] c_ST_FULL   = 2'd1;
    localparam logic [1:0] c_ST_STREAM = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [c_WW-1:0]  r_wr_idx;
    logic             r_strobe_q;
    logic             r_go_q;
    logic [c_RW-1:0]  r_win_row;
    logic [c_CW-1:0]  r_win_col;
    logic             r_frame_full;
    logic             r_ovf_err;
    logic [COLS-1:0]  r_mat [ROWS];

    logic w_strobe_edge;
    logic w_go_edge;
    logic w_accept;
    logic w_fill_write;

    assign w_strobe_edge = row_strobe & ~r_strobe_q;
    assign w_go_edge     = load_go & ~r_go_q;
    assign w_accept      = (r_state == c_ST_STREAM) & win_ready;
    assign w_fill_write  = w_strobe_edge & (r_state == c_ST_FILL);

    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_full = r_frame_full;
    assign ovf_err    = r_ovf_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        win_valid   = 1'b0;
        done        = 1'b0;
        case (r_state)
            c_ST_FILL: begin
                if (w_strobe_edge && (r_wr_idx == c_LAST_WR)) begin
                    w_state_nxt = c_ST_FULL;
                end
            end
            c_ST_FULL: begin
                if (w_go_edge) begin
                    w_state_nxt = c_ST_STREAM;
                end
            end
            c_ST_STREAM: begin
                win_valid = 1'b1;
                if (w_accept && (r_win_col == c_LAST_COL) && (r_win_row == c_LAST_ROW)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_ST_FILL;
            end
            default: begin
                w_state_nxt = c_ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_idx     <= '0;
            r_strobe_q   <= 1'b0;
            r_go_q       <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_full <= 1'b0;
            r_ovf_err    <= 1'b0;
        end else begin
            r_strobe_q <= row_strobe;
            r_go_q     <= load_go;

            // Rows arriving outside FILL are dropped and flagged, never stored
            if (w_strobe_edge) begin
                if (r_state == c_ST_FILL) begin
                    r_wr_idx <= r_wr_idx + c_WW'(1);
                    if (r_wr_idx == c_LAST_WR) begin
                        r_frame_full <= 1'b1;
                    end
                end else begin
                    r_ovf_err <= 1'b1;
                end
            end

            if ((r_state == c_ST_FULL) && w_go_edge) begin
                r_win_row <= '0;
                r_win_col <= '0;
            end

            if (w_accept) begin
                if (r_win_col == c_LAST_COL) begin
                    r_win_col <= '0;
                    if (r_win_row != c_LAST_ROW) begin
                        r_win_row <= r_win_row + c_RW'(1);
                    end
                end else begin
                    r_win_col <= r_win_col + c_CW'(1);
                end
            end

            if (r_state == c_ST_DONE) begin
                r_wr_idx     <= '0;
                r_frame_full <= 1'b0;
            end
        end
    end

    // Frame storage has no reset: contents persist until overwritten
    always_ff @(posedge clk) begin
        if (!rst && w_fill_write) begin
            r_mat[r_wr_idx[c_RW-1:0]] <= row_data;
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                win_data[i*K+j] = r_mat[r_win_row + c_RW'(i)][r_win_col + c_CW'(j)];
            end
        end
    end

endmodule
`default_nettype wire
